mac32_top: RTL and testbench
============================

MAC32_TOP -- requirements
Module: mac32_top

Interface
REQ-001 The parameter PARM_XLEN SHALL default to 32 and SHALL set the operand and result width.
REQ-002 The parameter PARM_EXP SHALL default to 8 and SHALL set the exponent field width.
REQ-003 The parameter PARM_MANT SHALL default to 23 and SHALL set the stored fraction width.
REQ-004 The parameter PARM_BIAS SHALL default to 127 and SHALL set the exponent bias.
REQ-005 The port list SHALL be: clk, input, 1 bit, the single clock; all state SHALL update on the rising edge.
REQ-006 The port list SHALL be: rst_n, input, 1 bit, reset; the block SHALL use one clock, and reset SHALL be asynchronous and active-low.
REQ-007 The port list SHALL be: A_i, input, PARM_XLEN bits, IEEE-754 binary32 multiplicand.
REQ-008 The port list SHALL be: B_i, input, PARM_XLEN bits, IEEE-754 binary32 multiplier.
REQ-009 The port list SHALL be: C_i, input, PARM_XLEN bits, IEEE-754 binary32 addend.
REQ-010 The port list SHALL be: Result_o, output, PARM_XLEN bits, registered result of A_i*B_i+C_i.
REQ-011 The block SHALL have no handshake; every clock edge SHALL accept a new operand triple.

Function
REQ-012 On each rising clk edge, Result_o SHALL load the fused value round(A_i*B_i + C_i).
- The product SHALL be exact: full 48-bit significand, no intermediate rounding.
- There SHALL be a single rounding step.
REQ-013 The latency SHALL be 1 cycle, and the throughput SHALL be 1 operation per cycle.
REQ-014 The rounding mode SHALL be round-to-nearest-even only.
- Guard, round and sticky bits SHALL be derived from the full-width aligned sum.
REQ-015 Subnormal inputs SHALL be treated as zero of the same sign (DAZ).
- Finite results below 2^-126 after rounding SHALL flush to a signed zero (FTZ).
REQ-016 Any NaN input SHALL produce the canonical qNaN 0x7FC00000.
REQ-017 inf*0 SHALL produce 0x7FC00000, with or without a NaN addend.
REQ-018 inf*x + (-inf), where the signs are opposite, SHALL produce 0x7FC00000.
REQ-019 Otherwise, an infinite product or an infinite addend SHALL produce an infinity with the sign of the infinite term.
REQ-020 A finite result whose exponent exceeds 254 after rounding SHALL produce ±inf (0x7F800000 or 0xFF800000).
REQ-021 An exact zero sum of opposite-signed terms SHALL produce +0.
- (+0)+(+0) SHALL produce +0.
- (-0)+(-0) SHALL produce -0.
REQ-022 When C is larger than the product, alignment SHALL handle shift distances up to 74 bits.
- Bits shifted out SHALL fold into sticky.
- A shift past the width SHALL leave sticky only.
REQ-023 Cancellation SHALL be normalized with a leading-zero count over the full sum width before rounding.
REQ-024 A mantissa carry-out from rounding SHALL increment the exponent.
- If that increment overflows the exponent, the result SHALL become inf.

Reset
REQ-025 While rst_n=0, Result_o SHALL be 32'h00000000, asynchronously and independent of clk.
REQ-026 Asserting reset mid-stream SHALL discard the in-flight result.
- The first edge after rst_n deasserts SHALL load the result for the operands present at that edge.

Structure
REQ-027 The package mac32_pkg SHALL hold:
- the default widths and the bias;
- the constants QNAN=0x7FC00000, POS_INF, NEG_INF;
- a packed struct for the sign/exponent/fraction fields.
REQ-028 The datapath SHALL be:
- combinational unpack, then special-case detection;
- multiply, then align, then add/subtract, then normalize, then round and pack;
- one output register.
REQ-029 One sub-module, mac32_lzc, SHALL be used: a parameterized leading-zero counter for normalization.

Verification
REQ-030 A=0x3F800000, B=0x40000000, C=0x40400000 -> one cycle later, Result_o=0x40A00000 (1*2+3=5).
REQ-031 A=0x7F800000, B=0x00000000, C=0x3F800000 -> Result_o=0x7FC00000.
REQ-032 A=0x3F800000, B=0x3F800000, C=0xBF800000 -> Result_o=0x00000000 (+0).
REQ-033 A=0x7F7FFFFF, B=0x40000000, C=0x00000000 -> Result_o=0x7F800000 (overflow).
REQ-034 A=0x3F800001, B=0x3F800001, C=0xBF800002 -> Result_o=0x28800000 (2^-46), which proves fused single rounding.
REQ-035 Pull rst_n low between edges while Result_o=0x40A00000 -> Result_o=0x00000000 immediately.
- After release, the next edge SHALL produce the result for the new operands.

Source files
------------

// File: rtl/mac32_pkg.sv
// Shared definitions for the single-precision fused multiply-add block.
// Holds the default format widths and bias, canonical special encodings,
// a field view of a binary32 word, and a width helper for the LZC.
package mac32_pkg;

  localparam int XLEN_DEF = 32;
  localparam int EXP_DEF  = 8;
  localparam int MANT_DEF = 23;
  localparam int BIAS_DEF = 127;

  localparam logic [31:0] QNAN    = 32'h7FC0_0000;
  localparam logic [31:0] POS_INF = 32'h7F80_0000;
  localparam logic [31:0] NEG_INF = 32'hFF80_0000;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] frac;
  } fp32_t;

  // Count width able to represent 0..w (w = all-zero input).
  function automatic int lzc_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/mac32_lzc.sv
// Parameterized leading-zero counter.
// Ports:
//   din   - vector to scan, MSB first
//   count - number of zeros above the highest set bit; WIDTH when din is zero
module mac32_lzc
  import mac32_pkg::*;
#(
  parameter int WIDTH = 76,
  parameter int CNT_W = lzc_width(WIDTH)
) (
  input  logic [WIDTH-1:0] din,
  output logic [CNT_W-1:0] count
);

  // Scanning upward lets the highest set bit overwrite lower ones.
  always_comb begin
    count = CNT_W'(WIDTH);
    for (int i = 0; i < WIDTH; i++) begin
      if (din[i]) count = CNT_W'(WIDTH - 1 - i);
    end
  end

endmodule

// File: rtl/mac32_top.sv
// Single-precision fused multiply-add: Result_o <= round_rne(A_i*B_i + C_i),
// one cycle latency, one operation per cycle. Subnormal inputs read as zero,
// tiny results flush to signed zero, NaNs collapse to the canonical qNaN.
// Ports:
//   clk      - clock, rising edge
//   rst_n    - asynchronous active-low reset, clears Result_o
//   A_i, B_i - multiplicand / multiplier
//   C_i      - addend
//   Result_o - registered fused result
module mac32_top
  import mac32_pkg::*;
#(
  parameter int PARM_XLEN = XLEN_DEF,
  parameter int PARM_EXP  = EXP_DEF,
  parameter int PARM_MANT = MANT_DEF,
  parameter int PARM_BIAS = BIAS_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [PARM_XLEN-1:0] A_i,
  input  logic [PARM_XLEN-1:0] B_i,
  input  logic [PARM_XLEN-1:0] C_i,
  output logic [PARM_XLEN-1:0] Result_o
);

  localparam int SIG = PARM_MANT + 1;   // significand with hidden bit
  localparam int PW  = 2 * SIG;         // exact product width
  localparam int LOW = SIG + 3;         // exact headroom below the larger term
  localparam int WW  = PW + LOW;        // alignment window
  localparam int SW  = WW + 1;          // sum width incl. carry
  localparam int EW  = PARM_EXP + 4;    // signed exponent work width
  localparam int CW  = lzc_width(SW);
  localparam logic [PARM_EXP-1:0]  EMAX     = '1;
  localparam logic signed [EW-1:0] EXP_TOP  = EW'((1 << PARM_EXP) - 1);
  localparam logic signed [EW-1:0] SH_MAX   = EW'(SW);
  localparam logic [PARM_XLEN-1:0] QNAN_VAL = {1'b0, {PARM_EXP{1'b1}}, 1'b1, {(PARM_MANT-1){1'b0}}};

  // Unpack and classify; index 0 = A, 1 = B, 2 = C.
  logic [PARM_XLEN-1:0] op [3];
  logic [2:0]           sgn, is_zero, is_inf, is_nan;
  logic [PARM_EXP-1:0]  ex  [3];
  logic [SIG-1:0]       sig [3];

  assign op[0] = A_i;
  assign op[1] = B_i;
  assign op[2] = C_i;

  always_comb begin
    logic [PARM_MANT-1:0] fr;
    fr = '0;
    for (int k = 0; k < 3; k++) begin
      sgn[k]     = op[k][PARM_XLEN-1];
      ex[k]      = op[k][PARM_XLEN-2 -: PARM_EXP];
      fr         = op[k][PARM_MANT-1:0];
      is_zero[k] = (ex[k] == '0);
      is_inf[k]  = (ex[k] == EMAX) && (fr == '0);
      is_nan[k]  = (ex[k] == EMAX) && (fr != '0);
      sig[k]     = is_zero[k] ? '0 : {1'b1, fr};
    end
  end

  // Special cases
  logic sp, sc, prod_zero, prod_inf, invalid;

  assign sp        = sgn[0] ^ sgn[1];
  assign sc        = sgn[2];
  assign prod_zero = is_zero[0] | is_zero[1];
  assign prod_inf  = is_inf[0] | is_inf[1];
  assign invalid   = (|is_nan)
                   | (is_inf[0] & is_zero[1]) | (is_zero[0] & is_inf[1])
                   | (prod_inf & is_inf[2] & (sp != sc));

  // Multiply; both terms share the scale X * 2^(E - bias - (PW-2)).
  logic [PW-1:0]          xp, xc, big_x, small_x;
  logic signed [EW-1:0]   ep, ec, ebig, esmall, d;
  logic                   c_big, sgn_big;

  assign xp = PW'(sig[0]) * PW'(sig[1]);
  assign xc = {1'b0, sig[2], {PARM_MANT{1'b0}}};
  assign ep = EW'(ex[0]) + EW'(ex[1]) - EW'(PARM_BIAS);
  assign ec = EW'(ex[2]);

  // A zero term must always be the one shifted, or it would push the real
  // operand's bits out of the window.
  assign c_big   = prod_zero | (!is_zero[2] & (ec > ep));
  assign big_x   = c_big ? xc : xp;
  assign small_x = c_big ? xp : xc;
  assign ebig    = c_big ? ec : ep;
  assign esmall  = c_big ? ep : ec;
  assign sgn_big = c_big ? sc : sp;
  assign d       = ebig - esmall;

  // Align: bits falling below the window collapse into a sticky LSB.
  logic [CW-1:0]   shamt;
  logic [2*WW-1:0] sh_full;
  logic [SW-1:0]   big_al, small_al, sum;
  logic            res_sign;

  always_comb begin
    if (d[EW-1])           shamt = '0;
    else if (d > SH_MAX)   shamt = CW'(SW);
    else                   shamt = d[CW-1:0];
  end

  assign sh_full  = {small_x, {LOW{1'b0}}, {WW{1'b0}}} >> shamt;
  assign small_al = {1'b0, sh_full[2*WW-1:WW]} | SW'(|sh_full[WW-1:0]);
  assign big_al   = {1'b0, big_x, {LOW{1'b0}}};

  // Add / subtract as sign-magnitude.
  always_comb begin
    sum      = big_al + small_al;
    res_sign = sgn_big;
    if (sp != sc) begin
      if (big_al >= small_al) begin
        sum = big_al - small_al;
      end else begin
        sum      = small_al - big_al;
        res_sign = !sgn_big;
      end
    end
  end

  // Normalize
  logic [CW-1:0]        lz;
  logic [SW-1:0]        norm;
  logic signed [EW-1:0] er, er_r;

  mac32_lzc #(.WIDTH(SW), .CNT_W(CW)) u_lzc (
    .din   (sum),
    .count (lz)
  );

  assign norm = sum << lz;
  // Leading one lands at SW-1, two places above the product's unit bit.
  assign er   = ebig + EW'(2) - EW'(lz);

  // Round to nearest even
  logic [SIG-1:0]       kept;
  logic                 guard, rnd, sticky, inc, carry;
  logic [PARM_MANT-1:0] frac_r;

  assign kept   = norm[SW-1 -: SIG];
  assign guard  = norm[SW-1-SIG];
  assign rnd    = norm[SW-2-SIG];
  assign sticky = |norm[SW-3-SIG:0];
  assign inc    = guard & (rnd | sticky | kept[0]);
  assign carry  = inc & (&kept);
  assign frac_r = kept[PARM_MANT-1:0] + PARM_MANT'(inc);  // wraps to 0 on carry
  assign er_r   = er + EW'(carry);

  // Pack
  logic [PARM_XLEN-1:0] result_d;

  always_comb begin
    result_d = {res_sign, er_r[PARM_EXP-1:0], frac_r};
    if (invalid)
      result_d = QNAN_VAL;
    else if (prod_inf)
      result_d = {sp, EMAX, {PARM_MANT{1'b0}}};
    else if (is_inf[2])
      result_d = {sc, EMAX, {PARM_MANT{1'b0}}};
    else if (sum == '0)
      result_d = {sp & sc, {(PARM_XLEN-1){1'b0}}};
    else if (er_r >= EXP_TOP)
      result_d = {res_sign, EMAX, {PARM_MANT{1'b0}}};
    else if (er_r[EW-1] || (er_r == '0))
      result_d = {res_sign, {(PARM_XLEN-1){1'b0}}};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) Result_o <= '0;
    else        Result_o <= result_d;
  end

endmodule

// File: tb/tb_mac32_top.sv
// Self-checking bench for mac32_top: directed corner vectors plus randomized
// operands checked against an exact-arithmetic reference model.
module tb_mac32_top;
  import mac32_pkg::*;

  logic        clk, rst_n;
  logic [31:0] A_i, B_i, C_i, Result_o;

  int n_checks = 0;
  int n_pass   = 0;

  mac32_top dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .A_i      (A_i),
    .B_i      (B_i),
    .C_i      (C_i),
    .Result_o (Result_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h", tag, got, exp);
  endtask

  // Reference: the true value as an exact integer in units of 2^-300,
  // then a single round-to-nearest-even to 24 significant bits.
  function automatic logic [31:0] ref_fma(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
    fp32_t fa, fb, fc;
    logic a_nan, b_nan, c_nan, a_inf, b_inf, c_inf, a_zero, b_zero, c_zero, sp, s;
    logic [47:0]  p48;
    logic [599:0] pm, cm, m, q, rem, half;
    int h, e, sh;
    fa = a; fb = b; fc = c;
    a_nan  = fa.exp == 8'hFF && fa.frac != 0;
    b_nan  = fb.exp == 8'hFF && fb.frac != 0;
    c_nan  = fc.exp == 8'hFF && fc.frac != 0;
    a_inf  = fa.exp == 8'hFF && fa.frac == 0;
    b_inf  = fb.exp == 8'hFF && fb.frac == 0;
    c_inf  = fc.exp == 8'hFF && fc.frac == 0;
    a_zero = fa.exp == 0;
    b_zero = fb.exp == 0;
    c_zero = fc.exp == 0;
    sp = fa.sign ^ fb.sign;
    if (a_nan || b_nan || c_nan) return QNAN;
    if ((a_inf && b_zero) || (a_zero && b_inf)) return QNAN;
    if (a_inf || b_inf) begin
      if (c_inf && sp != fc.sign) return QNAN;
      return sp ? NEG_INF : POS_INF;
    end
    if (c_inf) return fc.sign ? NEG_INF : POS_INF;
    pm = '0;
    cm = '0;
    if (!a_zero && !b_zero) begin
      p48 = 48'({1'b1, fa.frac}) * 48'({1'b1, fb.frac});
      pm  = 600'(p48) << (int'(fa.exp) + int'(fb.exp));
    end
    if (!c_zero) cm = 600'({1'b1, fc.frac}) << (int'(fc.exp) + 150);
    if (sp == fc.sign) begin
      m = pm + cm; s = sp;
    end else if (pm >= cm) begin
      m = pm - cm; s = sp;
    end else begin
      m = cm - pm; s = fc.sign;
    end
    if (m == 0) return {sp & fc.sign, 31'b0};
    h = 0;
    for (int i = 0; i < 600; i++) if (m[i]) h = i;
    e = h - 173;
    if (h > 23) begin
      sh   = h - 23;
      q    = m >> sh;
      rem  = m - (q << sh);
      half = 600'(1) << (sh - 1);
      if (rem > half || (rem == half && q[0])) q = q + 1;
    end else begin
      q = m << (23 - h);
    end
    if (q[24]) begin
      q = q >> 1;
      e = e + 1;
    end
    if (e >= 255) return s ? NEG_INF : POS_INF;
    if (e <= 0) return {s, 31'b0};
    return {s, 8'(e), q[22:0]};
  endfunction

  function automatic logic [31:0] rand_op();
    int unsigned sel;
    logic [31:0] v;
    sel = $urandom_range(0, 15);
    if (sel == 0) begin
      case ($urandom_range(0, 7))
        0: v = 32'h0000_0000;
        1: v = 32'h8000_0000;
        2: v = 32'h7F80_0000;
        3: v = 32'hFF80_0000;
        4: v = 32'h7F80_0001;
        5: v = 32'h0000_0123;
        6: v = 32'h7F7F_FFFF;
        default: v = 32'h0080_0000;
      endcase
    end else if (sel == 1) begin
      v = $urandom();
    end else begin
      v = {1'($urandom()), 8'($urandom_range(100, 154)), 23'($urandom())};
    end
    return v;
  endfunction

  // Drive at a falling edge, let the rising edge load, check at the next falling edge.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                        input logic [31:0] exp, input string tag);
    A_i = a; B_i = b; C_i = c;
    @(negedge clk);
    check_eq(tag, Result_o, exp);
  endtask

  initial begin
    logic [31:0] a, b, c;
    rst_n = 1'b0;
    A_i = 32'h3F80_0000; B_i = 32'h4000_0000; C_i = 32'h4040_0000;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("reset_hold", Result_o, 32'h0000_0000);
    rst_n = 1'b1;

    run_op(32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h40A0_0000, "one_two_three");
    run_op(32'h7F80_0000, 32'h0000_0000, 32'h3F80_0000, 32'h7FC0_0000, "inf_times_zero");
    run_op(32'h3F80_0000, 32'h3F80_0000, 32'hBF80_0000, 32'h0000_0000, "exact_cancel");
    run_op(32'h7F7F_FFFF, 32'h4000_0000, 32'h0000_0000, 32'h7F80_0000, "overflow");
    run_op(32'h3F80_0001, 32'h3F80_0001, 32'hBF80_0002, 32'h2880_0000, "fused_single_round");
    run_op(32'h7F80_0000, 32'h3F80_0000, 32'hFF80_0000, 32'h7FC0_0000, "inf_minus_inf");
    run_op(32'h3F80_0000, 32'h3F80_0000, 32'hFF80_0000, 32'hFF80_0000, "inf_addend");
    run_op(32'h7FC0_0001, 32'h3F80_0000, 32'h3F80_0000, 32'h7FC0_0000, "nan_input");
    run_op(32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, "pos_zero_sum");
    run_op(32'h8000_0000, 32'h0000_0000, 32'h8000_0000, 32'h8000_0000, "neg_zero_sum");
    run_op(32'h0000_0001, 32'h7F00_0000, 32'h0000_0000, 32'h0000_0000, "daz_input");
    run_op(32'h0080_0000, 32'h3F00_0000, 32'h0000_0000, 32'h0000_0000, "ftz_output");
    run_op(32'h3F7F_FFFF, 32'h3F80_0000, 32'h3300_0000, 32'h3F80_0000, "round_carry_exp");
    run_op(32'h7F7F_FFFF, 32'h3F80_0000, 32'h7300_0000, 32'h7F80_0000, "round_overflow");
    run_op(32'h3F80_0000, 32'h3F80_0000, 32'h5800_0000, 32'h5800_0000, "product_far_below");

    run_op(32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h40A0_0000, "pre_reset_value");
    A_i = 32'h4000_0000; B_i = 32'h4000_0000; C_i = 32'h0000_0000;
    #2 rst_n = 1'b0;
    #1 check_eq("async_reset", Result_o, 32'h0000_0000);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check_eq("first_after_reset", Result_o, 32'h4080_0000);

    for (int i = 0; i < 600; i++) begin
      a = rand_op();
      b = rand_op();
      c = rand_op();
      if ($urandom_range(0, 3) == 0) c = ref_fma(a, b, 32'h0) ^ 32'h8000_0000 ^ 32'($urandom_range(0, 3));
      run_op(a, b, c, ref_fma(a, b, c), "random");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
